// File: rtl/lane_press_ctrl.sv
// Per-lane press sequencer: key edges to highlight vector with frame-counted hold
// and cooldown, hit/miss judgment against the hit zone, and score counters.
module lane_press_ctrl #(
    parameter int HOLD_FRAMES = 6,
    parameter int COOL_FRAMES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [7:0]  key_raw,
    input  logic [7:0]  note_in_window,
    output logic [7:0]  keyTrack,
    output logic [7:0]  hit_pulse,
    output logic [7:0]  miss_pulse,
    output logic [15:0] hit_total,
    output logic [7:0]  streak
);

    typedef enum logic [1:0] {IDLE, PRESS, COOL} lane_state_e;

    localparam logic [7:0] HOLD_LD = 8'(HOLD_FRAMES);
    localparam logic [7:0] COOL_LD = 8'(COOL_FRAMES);

    lane_state_e state_q [8];
    lane_state_e state_d [8];
    logic [7:0]  cnt_q   [8];
    logic [7:0]  cnt_d   [8];

    logic [7:0]  key_prev_q, key_prev_d;
    logic [7:0]  key_track_q, key_track_d;
    logic [7:0]  hit_q, hit_d;
    logic [7:0]  miss_q, miss_d;
    logic [15:0] hit_total_q, hit_total_d;
    logic [7:0]  streak_q, streak_d;

    logic [7:0]  rise;
    logic [3:0]  hit_cnt;
    logic [16:0] ht_sum;
    logic [8:0]  st_sum;

    always_comb begin
        rise        = key_raw & ~key_prev_q;
        key_prev_d  = key_raw;
        hit_d       = '0;
        miss_d      = '0;
        key_track_d = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = PRESS;
                        cnt_d[i]   = HOLD_LD;
                        if (note_in_window[i]) hit_d[i] = 1'b1;
                        else                   miss_d[i] = 1'b1;
                    end
                end
                PRESS: begin
                    if (cnt_q[i] == '0 && !key_raw[i]) begin
                        if (COOL_FRAMES > 0) begin
                            state_d[i] = COOL;
                            cnt_d[i]   = COOL_LD;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end else if (frame_tick && cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - 8'd1;
                    end
                end
                COOL: begin
                    // IDLE only once cnt has been observed at zero, not on the tick that zeroes it
                    if (cnt_q[i] == '0)   state_d[i] = IDLE;
                    else if (frame_tick)  cnt_d[i]   = cnt_q[i] - 8'd1;
                end
                default: state_d[i] = IDLE;
            endcase
            key_track_d[i] = (state_d[i] == PRESS);
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            hit_cnt = hit_cnt + {3'b000, hit_q[i]};
        end
        ht_sum      = {1'b0, hit_total_q} + 17'(hit_cnt);
        hit_total_d = ht_sum[16] ? '1 : ht_sum[15:0];
        st_sum      = {1'b0, streak_q} + 9'(hit_cnt);
        // A miss on any lane clears the streak even if other lanes hit this cycle
        if (|miss_q)        streak_d = '0;
        else if (st_sum[8]) streak_d = '1;
        else                streak_d = st_sum[7:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            key_prev_q  <= '0;
            key_track_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            hit_total_q <= '0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_prev_q  <= key_prev_d;
            key_track_q <= key_track_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            hit_total_q <= hit_total_d;
            streak_q    <= streak_d;
        end
    end

    assign keyTrack   = key_track_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign hit_total  = hit_total_q;
    assign streak     = streak_q;

endmodule

// File: tb/tb_lane_press_ctrl.sv
// Directed bench for lane_press_ctrl: expectations queued per step, compared after each edge.
module tb_lane_press_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [7:0]  key_raw = '0;
    logic [7:0]  note_in_window = '0;
    logic [7:0]  keyTrack, hit_pulse, miss_pulse, streak;
    logic [15:0] hit_total;

    lane_press_ctrl #(.HOLD_FRAMES(6), .COOL_FRAMES(2)) dut (
        .Clk(clk), .Reset(rst), .frame_tick(frame_tick), .key_raw(key_raw),
        .note_in_window(note_in_window), .keyTrack(keyTrack), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .hit_total(hit_total), .streak(streak)
    );

    always #5 clk = ~clk;

    localparam int KT = 0, HP = 1, MP = 2, HT = 3, ST = 4;

    typedef struct {
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t  sb[$];
    int    tests = 0;
    int    fails = 0;
    string phase = "reset";

    task automatic push(input int sel, input logic [15:0] val);
        exp_t e;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [15:0] obs;
        string       name;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                KT:      begin obs = {8'h00, keyTrack};   name = "keyTrack";   end
                HP:      begin obs = {8'h00, hit_pulse};  name = "hit_pulse";  end
                MP:      begin obs = {8'h00, miss_pulse}; name = "miss_pulse"; end
                HT:      begin obs = hit_total;           name = "hit_total";  end
                default: begin obs = {8'h00, streak};     name = "streak";     end
            endcase
            tests++;
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s/%s: observed %0h expected %0h", phase, name, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input logic [7:0] k, input logic [7:0] n, input logic f);
        key_raw        = k;
        note_in_window = n;
        frame_tick     = f;
        @(posedge clk);
        #1;
        check_sb();
    endtask

    // One 4-cycle frame with the tick in its first cycle; no judgments expected
    task automatic frame(input logic [7:0] k, input logic [7:0] kt);
        for (int c = 0; c < 4; c++) begin
            push(KT, {8'h00, kt});
            push(HP, 16'h0000);
            push(MP, 16'h0000);
            cyc(k, 8'h00, (c == 0));
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cyc(8'h00, 8'h00, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        push(KT, 0); push(HP, 0); push(MP, 0); push(HT, 0); push(ST, 0);
        check_sb();
        rst = 1'b0;

        phase = "idle";
        for (int c = 0; c < 6; c++) begin
            push(KT, 0); push(HT, 0); push(ST, 0);
            cyc(8'h00, 8'h00, c[0]);
        end

        phase = "lane7_hit";
        push(KT, 16'h80); push(HP, 16'h80); push(MP, 0); push(HT, 0);
        cyc(8'h80, 8'h80, 1'b0);
        push(KT, 16'h80); push(HP, 0); push(HT, 1); push(ST, 1);
        cyc(8'h80, 8'h00, 1'b0);
        frame(8'h80, 8'h80);
        frame(8'h80, 8'h80);
        frame(8'h00, 8'h80);
        frame(8'h00, 8'h80);
        frame(8'h00, 8'h80);
        phase = "lane7_expire";
        push(KT, 16'h80);
        cyc(8'h00, 8'h00, 1'b1);
        push(KT, 0);
        cyc(8'h00, 8'h00, 1'b0);
        phase = "lane7_cool";
        push(KT, 0); push(HP, 0); push(MP, 0);
        cyc(8'h80, 8'h80, 1'b0);
        push(KT, 0); push(HP, 0); push(MP, 0);
        cyc(8'h80, 8'h80, 1'b1);
        push(KT, 0); push(HP, 0); push(MP, 0);
        cyc(8'h80, 8'h80, 1'b1);
        push(KT, 0); push(HP, 0); push(MP, 0);
        cyc(8'h80, 8'h80, 1'b0);
        phase = "lane7_held_idle";
        push(KT, 0); push(HP, 0); push(MP, 0);
        cyc(8'h80, 8'h80, 1'b0);
        push(HT, 1); push(ST, 1); push(KT, 0);
        cyc(8'h00, 8'h00, 1'b0);

        phase = "lanes0_4";
        push(KT, 16'h11); push(HP, 16'h01); push(MP, 16'h10);
        cyc(8'h11, 8'h01, 1'b0);
        push(HT, 2); push(ST, 0);
        cyc(8'h00, 8'h00, 1'b0);
        idle(12);
        push(KT, 0);
        cyc(8'h00, 8'h00, 1'b0);

        phase = "hold20";
        push(KT, 16'h08); push(MP, 16'h08); push(HP, 0);
        cyc(8'h08, 8'h00, 1'b0);
        for (int f = 0; f < 20; f++) frame(8'h08, 8'h08);
        push(HT, 2); push(ST, 0); push(KT, 0);
        cyc(8'h00, 8'h00, 1'b0);
        push(KT, 0); push(HP, 0); push(MP, 0);
        cyc(8'h08, 8'h08, 1'b0);
        idle(12);

        phase = "reset_mid_press";
        push(KT, 16'h62); push(HP, 16'h62);
        cyc(8'h62, 8'h62, 1'b0);
        push(HT, 5); push(ST, 3); push(KT, 16'h62);
        cyc(8'h62, 8'h62, 1'b0);
        #3 rst = 1'b1;
        #1;
        push(KT, 0); push(HT, 0); push(ST, 0);
        check_sb();
        @(posedge clk);
        #1;
        push(KT, 0);
        check_sb();
        rst = 1'b0;
        phase = "post_reset_rise";
        push(KT, 16'h62); push(HP, 16'h62); push(HT, 0);
        cyc(8'h62, 8'h62, 1'b0);
        push(HT, 3); push(ST, 3);
        cyc(8'h00, 8'h00, 1'b0);
        idle(12);
        rst = 1'b1;
        #2 rst = 1'b0;
        push(HT, 0); push(ST, 0);
        check_sb();

        phase = "streak300";
        for (int n = 1; n <= 300; n++) begin
            push(HP, 16'h04); push(MP, 0);
            cyc(8'h04, 8'h04, 1'b0);
            push(HT, 16'(n)); push(ST, (n > 255) ? 16'd255 : 16'(n));
            cyc(8'h00, 8'h00, 1'b1);
            idle(11);
        end
        phase = "streak_miss";
        push(MP, 16'h04); push(HP, 0);
        cyc(8'h04, 8'h00, 1'b0);
        push(ST, 0); push(HT, 16'd300);
        cyc(8'h00, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
